// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a single registered ALU.
// One operation in flight at a time: IDLE accepts, WAIT counts ALU latency, RESP pulses the owner.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 3,
  parameter int CW      = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             resp0_valid,
  output logic [CW-1:0]    resp0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp1_valid,
  output logic [CW-1:0]    resp1_c,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [CW-1:0]    alu_c,
  output logic             busy
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic             owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             any_req;
  logic             grant;
  logic             hs;
  logic             cap;

  // On conflict the requester that did not win last time goes first.
  always_comb begin
    any_req = req0_valid | req1_valid;
    grant   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    cnt_nxt        = cnt;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    hs             = 1'b0;
    cap            = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req && !reset) begin
          req0_ready     = ~grant;
          req1_ready     = grant;
          hs             = 1'b1;
          owner_nxt      = grant;
          last_grant_nxt = grant;
          cnt_nxt        = CNT_W'(ALU_LAT - 1);
          state_nxt      = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          cap       = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Operands stay put after issue so the ALU sees stable inputs for its whole latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      resp0_c    <= '0;
      resp1_c    <= '0;
    end else begin
      if (hs) begin
        alu_a      <= grant ? req1_a  : req0_a;
        alu_b      <= grant ? req1_b  : req0_b;
        alu_opcode <= grant ? req1_op : req0_op;
      end
      if (cap && !owner) resp0_c <= alu_c;
      if (cap && owner)  resp1_c <= alu_c;
    end
  end

  always_comb begin
    resp0_valid = (state == RESP) & ~owner;
    resp1_valid = (state == RESP) & owner;
    busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level scoreboard on a latency-1 instance plus a latency-3 instance.
module tb_alu_arbiter;
  localparam int WIDTH = 8;
  localparam int OPW   = 3;
  localparam int CW    = 16;
  localparam int LAT   = 1;
  localparam int LAT3  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic             resp0_valid, resp1_valid, busy;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [OPW-1:0]   req0_op, req1_op, alu_opcode;
  logic [CW-1:0]    resp0_c, resp1_c, alu_c;

  logic             t_v, t_rdy, t_rdy1, t_rv0, t_rv1, t_busy;
  logic [WIDTH-1:0] t_a, t_b, t_alu_a, t_alu_b;
  logic [OPW-1:0]   t_op, t_alu_op;
  logic [CW-1:0]    t_c0, t_c1, t_alu_c, t_pipe1, t_pipe2;

  int checks = 0;
  int errors = 0;

  function automatic logic [CW-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic [OPW-1:0] op);
    case (op)
      3'd0:    return CW'(a) + CW'(b);
      3'd1:    return CW'(a) - CW'(b);
      3'd2:    return CW'(a & b);
      3'd3:    return CW'(a | b);
      3'd4:    return CW'(a ^ b);
      3'd5:    return CW'(a) * CW'(b);
      3'd6:    return {a, b};
      default: return CW'(a) << b[2:0];
    endcase
  endfunction

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CW(CW), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_c(resp0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_c(resp1_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c), .busy(busy)
  );

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CW(CW), .ALU_LAT(LAT3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(t_v), .req0_ready(t_rdy), .req0_a(t_a), .req0_b(t_b),
    .req0_op(t_op), .resp0_valid(t_rv0), .resp0_c(t_c0),
    .req1_valid(1'b0), .req1_ready(t_rdy1), .req1_a('0), .req1_b('0),
    .req1_op('0), .resp1_valid(t_rv1), .resp1_c(t_c1),
    .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_opcode(t_alu_op), .alu_c(t_alu_c), .busy(t_busy)
  );

  // ALU models: latency 1 is combinational on the registered operands, latency 3 adds two stages.
  assign alu_c = alu_fn(alu_a, alu_b, alu_opcode);
  always @(posedge clk) begin
    t_pipe1 <= alu_fn(t_alu_a, t_alu_b, t_alu_op);
    t_pipe2 <= t_pipe1;
  end
  assign t_alu_c = t_pipe2;

  // Scoreboard state: when the block is next free, which response is due, last issued operands.
  int               cyc = 0;
  int               m_free, m_due;
  logic             m_port, m_last, sb_g, sb_e0, sb_e1;
  logic [CW-1:0]    m_res, m_c0, m_c1;
  logic [WIDTH-1:0] m_a, m_b;
  logic [OPW-1:0]   m_op;
  logic [4:0]       sb_exp, sb_got;
  int               hs_cyc[$], rs_cyc[$];
  bit               hs_port[$], rs_port[$];

  always @(negedge clk) begin
    cyc++;
    sb_got = {req0_ready, req1_ready, resp0_valid, resp1_valid, busy};
    if (req0_valid && req0_ready) begin hs_cyc.push_back(cyc); hs_port.push_back(1'b0); end
    if (req1_valid && req1_ready) begin hs_cyc.push_back(cyc); hs_port.push_back(1'b1); end
    if (resp0_valid) begin rs_cyc.push_back(cyc); rs_port.push_back(1'b0); end
    if (resp1_valid) begin rs_cyc.push_back(cyc); rs_port.push_back(1'b1); end
    if (reset) begin
      m_free = 0; m_due = -1; m_last = 1'b1; m_port = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_c0 = '0; m_c1 = '0;
      checks++;
      if (sb_got !== 5'b0 || {resp0_c, resp1_c, alu_a, alu_b, alu_opcode} !== '0) begin
        errors++;
        $display("FAIL sb_reset_outputs got ctrl=%b c0=%h c1=%h alu=%h/%h/%h required all zero",
                 sb_got, resp0_c, resp1_c, alu_a, alu_b, alu_opcode);
      end
    end else begin
      sb_e0 = 1'b0; sb_e1 = 1'b0; sb_g = 1'b0;
      if (cyc >= m_free && (req0_valid || req1_valid)) begin
        sb_g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
        sb_e0 = !sb_g;
        sb_e1 = sb_g;
      end
      if (cyc == m_due) begin
        if (m_port) m_c1 = m_res; else m_c0 = m_res;
      end
      sb_exp = {sb_e0, sb_e1, (cyc == m_due) && !m_port, (cyc == m_due) && m_port, cyc < m_free};
      checks++;
      if (sb_got !== sb_exp) begin
        errors++;
        $display("FAIL sb_ctrl cyc=%0d got {rdy0,rdy1,rv0,rv1,busy}=%b required %b", cyc, sb_got, sb_exp);
      end
      checks++;
      if ({resp0_c, resp1_c} !== {m_c0, m_c1}) begin
        errors++;
        $display("FAIL sb_resp_c cyc=%0d got %h/%h required %h/%h", cyc, resp0_c, resp1_c, m_c0, m_c1);
      end
      checks++;
      if ({alu_a, alu_b, alu_opcode} !== {m_a, m_b, m_op}) begin
        errors++;
        $display("FAIL sb_alu_ops cyc=%0d got %h/%h/%h required %h/%h/%h",
                 cyc, alu_a, alu_b, alu_opcode, m_a, m_b, m_op);
      end
      if (sb_e0 || sb_e1) begin
        m_a    = sb_g ? req1_a  : req0_a;
        m_b    = sb_g ? req1_b  : req0_b;
        m_op   = sb_g ? req1_op : req0_op;
        m_res  = alu_fn(m_a, m_b, m_op);
        m_port = sb_g;
        m_last = sb_g;
        m_free = cyc + LAT + 2;
        m_due  = cyc + LAT + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_cyc.delete(); hs_port.delete(); rs_cyc.delete(); rs_port.delete();
  endtask

  task automatic new_payload(input bit p);
    if (!p) begin
      req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_op = OPW'($urandom);
    end else begin
      req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_op = OPW'($urandom);
    end
  endtask

  // Holds each port valid until n0/n1 operations have been accepted.
  task automatic drive_ops(input int n0, input int n1, input int budget, output bit timed_out);
    int r0, r1, k;
    bit h0, h1;
    r0 = n0; r1 = n1; k = 0;
    req0_valid = (r0 > 0); new_payload(1'b0);
    req1_valid = (r1 > 0); new_payload(1'b1);
    while ((r0 > 0 || r1 > 0) && k < budget) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      step();
      k++;
      if (h0) begin r0--; req0_valid = (r0 > 0); new_payload(1'b0); end
      if (h1) begin r1--; req1_valid = (r1 > 0); new_payload(1'b1); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    timed_out = (r0 > 0 || r1 > 0);
    repeat (LAT + 3) step();
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, busy});
    end
    checks++;
    if ({alu_a, alu_b, alu_opcode, resp0_c, resp1_c} !== '0) begin
      errors++;
      $display("FAIL reset_data got alu=%h/%h/%h c=%h/%h required zero", alu_a, alu_b, alu_opcode,
               resp0_c, resp1_c);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    clear_log();
    req0_a = 8'h05; req0_b = 8'h03; req0_op = 3'd0; req0_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL t1_ready got rdy0=%b rdy1=%b required 1/0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_early_resp got %b required 0 in cycle 1", resp0_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b1 || resp0_c !== 16'h0008) begin
      errors++;
      $display("FAIL t1_resp got valid=%b c=%h required 1/0008", resp0_valid, resp0_c);
    end
    step();
    @(negedge clk);
    checks++;
    if (resp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_pulse_width got %b required 0 in cycle 3", resp0_valid);
    end
    step();
    checks++;
    if (rs_port.size() != 1 || rs_port[0] !== 1'b0) begin
      errors++;
      $display("FAIL t1_resp_count got %0d responses required one on port 0", rs_port.size());
    end
  endtask

  task automatic test_conflict();
    bit to;
    reset = 1'b1; step(); reset = 1'b0; step();
    clear_log();
    drive_ops(1, 1, 20, to);
    checks++;
    if (to || hs_port.size() != 2) begin
      errors++;
      $display("FAIL t2_handshakes got count=%0d timeout=%0b required 2/0", hs_port.size(), to);
    end else begin
      checks++;
      if (hs_port[0] !== 1'b0 || hs_port[1] !== 1'b1 || hs_cyc[1] - hs_cyc[0] != LAT + 2) begin
        errors++;
        $display("FAIL t2_grant_order got %0d,%0d gap %0d required 0,1 gap %0d",
                 hs_port[0], hs_port[1], hs_cyc[1] - hs_cyc[0], LAT + 2);
      end
    end
    checks++;
    if (rs_port.size() != 2) begin
      errors++;
      $display("FAIL t2_resp_count got %0d required 2", rs_port.size());
    end else if (rs_port[0] !== 1'b0 || rs_port[1] !== 1'b1 || rs_cyc[1] - rs_cyc[0] != 3) begin
      errors++;
      $display("FAIL t2_resp_order got %0d,%0d gap %0d required 0,1 gap 3",
               rs_port[0], rs_port[1], rs_cyc[1] - rs_cyc[0]);
    end
  endtask

  task automatic test_alternate();
    bit to;
    clear_log();
    drive_ops(3, 3, 60, to);
    checks++;
    if (to || hs_port.size() != 6 || rs_port.size() != 6) begin
      errors++;
      $display("FAIL t3_counts got hs=%0d resp=%0d timeout=%0b required 6/6/0",
               hs_port.size(), rs_port.size(), to);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (hs_port[i] !== 1'(i % 2) || rs_port[i] !== 1'(i % 2)) begin
          errors++;
          $display("FAIL t3_alternation op=%0d got grant=%0d resp=%0d required %0d",
                   i, hs_port[i], rs_port[i], i % 2);
        end
      end
      checks++;
      if (hs_cyc[5] - hs_cyc[0] != 5 * (LAT + 2)) begin
        errors++;
        $display("FAIL t3_throughput got span %0d required %0d", hs_cyc[5] - hs_cyc[0], 5 * (LAT + 2));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_log();
    drive_ops(0, 2, 20, to);
    checks++;
    if (to || hs_port.size() != 2 || rs_port.size() != 2) begin
      errors++;
      $display("FAIL t4_counts got hs=%0d resp=%0d timeout=%0b required 2/2/0",
               hs_port.size(), rs_port.size(), to);
    end else if (hs_port[0] !== 1'b1 || hs_port[1] !== 1'b1 || rs_port[0] !== 1'b1 ||
                 rs_port[1] !== 1'b1 || hs_cyc[1] - hs_cyc[0] != LAT + 2) begin
      errors++;
      $display("FAIL t4_grants got %0d,%0d gap %0d required 1,1 gap %0d",
               hs_port[0], hs_port[1], hs_cyc[1] - hs_cyc[0], LAT + 2);
    end
  endtask

  task automatic test_reset_in_wait();
    bit to;
    clear_log();
    new_payload(1'b0);
    req0_valid = 1'b1;
    @(negedge clk);
    step();
    req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t5_in_wait got busy=%b required 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, resp0_valid, resp1_valid, alu_a, alu_b, alu_opcode, resp0_c} !== '0) begin
      errors++;
      $display("FAIL t5_async_clear got busy=%b rv=%b%b alu=%h/%h/%h c0=%h required zero",
               busy, resp0_valid, resp1_valid, alu_a, alu_b, alu_opcode, resp0_c);
    end
    @(negedge clk);
    step();
    reset = 1'b0;
    repeat (5) step();
    checks++;
    if (rs_cyc.size() != 0) begin
      errors++;
      $display("FAIL t5_dropped_op got %0d responses required 0", rs_cyc.size());
    end
    clear_log();
    drive_ops(1, 0, 20, to);
    checks++;
    if (to || rs_port.size() != 1 || rs_port[0] !== 1'b0) begin
      errors++;
      $display("FAIL t5_after_reset got resp=%0d timeout=%0b required one on port 0",
               rs_port.size(), to);
    end
  endtask

  task automatic test_lat3();
    logic [WIDTH-1:0] a, b;
    logic [CW-1:0]    exp;
    a = WIDTH'($urandom_range(1, 255));
    b = WIDTH'($urandom);
    exp = alu_fn(a, b, 3'd0);
    t_a = a; t_b = b; t_op = 3'd0; t_v = 1'b1;
    @(negedge clk);
    checks++;
    if (t_rdy !== 1'b1) begin
      errors++;
      $display("FAIL t6_ready got %b required 1", t_rdy);
    end
    step();
    t_v = 1'b0; t_a = ~a; t_b = ~b; t_op = 3'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (c <= 3 && ({t_alu_a, t_alu_b, t_alu_op} !== {a, b, 3'd0} || t_rv0 !== 1'b0 || t_busy !== 1'b1)) begin
        errors++;
        $display("FAIL t6_wait cyc=%0d got alu=%h/%h/%h rv0=%b busy=%b required %h/%h/0 0 1",
                 c, t_alu_a, t_alu_b, t_alu_op, t_rv0, t_busy, a, b);
      end
      if (c == 4 && (t_rv0 !== 1'b1 || t_c0 !== exp || t_busy !== 1'b1)) begin
        errors++;
        $display("FAIL t6_resp got rv0=%b c0=%h busy=%b required 1/%h/1", t_rv0, t_c0, t_busy, exp);
      end
      if (c == 5 && (t_rv0 !== 1'b0 || t_busy !== 1'b0 || t_c0 !== exp)) begin
        errors++;
        $display("FAIL t6_idle got rv0=%b busy=%b c0=%h required 0/0/%h", t_rv0, t_busy, t_c0, exp);
      end
      checks++;
      if (t_rv1 !== 1'b0 || t_rdy1 !== 1'b0) begin
        errors++;
        $display("FAIL t6_port1_quiet cyc=%0d got rv1=%b rdy1=%b required 0/0", c, t_rv1, t_rdy1);
      end
      step();
    end
  endtask

  task automatic test_random();
    bit h0, h1;
    clear_log();
    for (int k = 0; k < 400; k++) begin
      if (!req0_valid) begin
        if ($urandom_range(0, 1) == 1) begin req0_valid = 1'b1; new_payload(1'b0); end
      end else if ($urandom_range(0, 9) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid) begin
        if ($urandom_range(0, 1) == 1) begin req1_valid = 1'b1; new_payload(1'b1); end
      end else if ($urandom_range(0, 9) == 0) begin
        req1_valid = 1'b0;
      end
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      step();
      if (h0) begin req0_valid = 1'($urandom_range(0, 1)); new_payload(1'b0); end
      if (h1) begin req1_valid = 1'($urandom_range(0, 1)); new_payload(1'b1); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (LAT + 3) step();
    checks++;
    if (hs_cyc.size() < 40 || rs_cyc.size() != hs_cyc.size()) begin
      errors++;
      $display("FAIL rand_activity got hs=%0d resp=%0d required >=40 and equal",
               hs_cyc.size(), rs_cyc.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    t_v = 1'b0; t_a = '0; t_b = '0; t_op = '0;
    test_reset();
    test_single();
    test_conflict();
    test_alternate();
    test_back_to_back();
    test_reset_in_wait();
    test_lat3();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
